// File: rtl/ser_pkg.sv
// Shared definitions for the byte serializer: one-hot FSM states and the
// bit-counter width helper.
package ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b01,
      ST_SHIFT = 2'b10
   } serState_e;

   // A counter for n states needs at least one bit even when n is 2.
   function automatic int cntWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / bit-out bundle between the word producer, the serializer and the
// 101 detector that consumes the serial stream.
interface byte_serializer_if #(
   parameter int DATA_W = 8
);

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              ser_data;
   logic              ser_valid;
   logic              frame_start;
   logic              busy;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  ser_data,
      input  ser_valid,
      input  frame_start,
      input  busy
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output ser_data,
      output ser_valid,
      output frame_start,
      output busy
   );

endinterface

// File: rtl/byte_serializer_counter.sv
// Modulo-N bit counter: counts 0..N-1 while enabled and flags the final count.
module mod_n_counter
   import ser_pkg::*;
#(
   parameter int N = 8,
   localparam int CW = cntWidth(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          last
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over enable so a reload on the final count restarts at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial stage feeding the 101 detector: words arrive on a
// valid/ready handshake and leave one bit per clock, idle level in between.
module byte_serializer
   import ser_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input logic              clk,
   input logic              rst,
   byte_serializer_if.slave bus
);

   localparam int CW = cntWidth(DATA_W);

   serState_e         state_q;
   logic [DATA_W-1:0] shift_q;
   logic              serData_q;
   logic              serValid_q;
   logic              frameStart_q;
   logic              busy_q;

   logic              accept;
   logic              lastBit;
   logic              inShift;
   logic [CW-1:0]     bitCntUnused;
   logic [DATA_W-1:0] loadShift_d;
   logic [DATA_W-1:0] stepShift_d;
   logic              firstBit_d;
   logic              nextBit_d;

   // The bit on ser_data already lives in serData_q, so the shift register
   // only ever holds the bits that are still to come.
   if (MSB_FIRST) begin : g_msbFirst
      assign firstBit_d  = bus.in_data[DATA_W-1];
      assign loadShift_d = bus.in_data << 1;
      assign nextBit_d   = shift_q[DATA_W-1];
      assign stepShift_d = shift_q << 1;
   end else begin : g_lsbFirst
      assign firstBit_d  = bus.in_data[0];
      assign loadShift_d = bus.in_data >> 1;
      assign nextBit_d   = shift_q[0];
      assign stepShift_d = shift_q >> 1;
   end

   assign inShift      = (state_q == ST_SHIFT);
   assign bus.in_ready = ~rst & ((state_q == ST_IDLE) | (inShift & lastBit));
   assign accept       = bus.in_valid & bus.in_ready;

   mod_n_counter #(
      .N (DATA_W)
   ) u_bitCnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (inShift),
      .cnt  (bitCntUnused),
      .last (lastBit)
   );

   // An accept on the last-bit cycle reloads in place, so consecutive words
   // run with no idle gap while the state stays SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         serData_q    <= IDLE_BIT;
         serValid_q   <= 1'b0;
         frameStart_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q      <= ST_SHIFT;
                  shift_q      <= loadShift_d;
                  serData_q    <= firstBit_d;
                  serValid_q   <= 1'b1;
                  frameStart_q <= 1'b1;
                  busy_q       <= 1'b1;
               end else begin
                  serData_q    <= IDLE_BIT;
                  serValid_q   <= 1'b0;
                  frameStart_q <= 1'b0;
                  busy_q       <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (!lastBit) begin
                  shift_q      <= stepShift_d;
                  serData_q    <= nextBit_d;
                  serValid_q   <= 1'b1;
                  frameStart_q <= 1'b0;
                  busy_q       <= 1'b1;
               end else if (accept) begin
                  shift_q      <= loadShift_d;
                  serData_q    <= firstBit_d;
                  serValid_q   <= 1'b1;
                  frameStart_q <= 1'b1;
                  busy_q       <= 1'b1;
               end else begin
                  state_q      <= ST_IDLE;
                  serData_q    <= IDLE_BIT;
                  serValid_q   <= 1'b0;
                  frameStart_q <= 1'b0;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               shift_q      <= '0;
               serData_q    <= IDLE_BIT;
               serValid_q   <= 1'b0;
               frameStart_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ser_data    = serData_q;
   assign bus.ser_valid   = serValid_q;
   assign bus.frame_start = frameStart_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: three configurations (8-bit MSB-first, 8-bit
// LSB-first, 3-bit with idle level 1) checked every cycle against a bit-queue model.
module tb_byte_serializer;

   logic clk;
   logic rst;

   int errors = 0;
   int checks = 0;

   int    WID  [3] = '{8, 8, 3};
   bit    MSB  [3] = '{1'b1, 1'b0, 1'b1};
   bit    IDL  [3] = '{1'b0, 1'b0, 1'b1};
   string NAME [3] = '{"A", "B", "C"};

   bit          vValid [3];
   logic [31:0] vData  [3];

   // Reference model: bits still owed to the stream, in emission order (bit 0 next).
   int          pendCnt  [3];
   logic [31:0] pendBits [3];
   logic        mBit     [3];
   logic        mValid   [3];
   logic        mFs      [3];

   typedef struct {
      int          inst;
      logic [31:0] word;
      int          nBits;
      logic [31:0] expSer;
      int          exp101;
   } vec_t;

   vec_t vecs [7];

   byte_serializer_if #(.DATA_W(8)) busA ();
   byte_serializer_if #(.DATA_W(8)) busB ();
   byte_serializer_if #(.DATA_W(3)) busC ();

   byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutA (
      .clk (clk), .rst (rst), .bus (busA)
   );
   byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dutB (
      .clk (clk), .rst (rst), .bus (busB)
   );
   byte_serializer #(.DATA_W(3), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dutC (
      .clk (clk), .rst (rst), .bus (busC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] emitOrder(int i, logic [31:0] d);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < WID[i]; j++) begin
         r[j] = MSB[i] ? d[WID[i]-1-j] : d[j];
      end
      return r;
   endfunction

   function automatic void modelReset(int i);
      pendCnt[i]  = 0;
      pendBits[i] = '0;
      mBit[i]     = IDL[i];
      mValid[i]   = 1'b0;
      mFs[i]      = 1'b0;
   endfunction

   function automatic void modelAdvance(int i, bit acc);
      bit fresh;
      fresh = 1'b0;
      if (acc) begin
         pendBits[i] = emitOrder(i, vData[i]);
         pendCnt[i]  = WID[i];
         fresh       = 1'b1;
      end
      if (pendCnt[i] > 0) begin
         mBit[i]     = pendBits[i][0];
         pendBits[i] = pendBits[i] >> 1;
         pendCnt[i]  = pendCnt[i] - 1;
         mValid[i]   = 1'b1;
         mFs[i]      = fresh;
      end else begin
         mBit[i]   = IDL[i];
         mValid[i] = 1'b0;
         mFs[i]    = 1'b0;
      end
   endfunction

   function automatic int count101(logic [31:0] s, int n);
      int c;
      c = 0;
      for (int j = 0; j + 2 < n; j++) begin
         if (s[j+2] == 1'b1 && s[j+1] == 1'b0 && s[j] == 1'b1) c++;
      end
      return c;
   endfunction

   // {ser_data, ser_valid, frame_start, busy, in_ready}
   function automatic logic [4:0] outs(int i);
      case (i)
         0:       return {busA.ser_data, busA.ser_valid, busA.frame_start, busA.busy, busA.in_ready};
         1:       return {busB.ser_data, busB.ser_valid, busB.frame_start, busB.busy, busB.in_ready};
         default: return {busC.ser_data, busC.ser_valid, busC.frame_start, busC.busy, busC.in_ready};
      endcase
   endfunction

   task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      logic [4:0] o;
      for (int i = 0; i < 3; i++) begin
         o = outs(i);
         checkVal({NAME[i], ".ser_data"},    32'(o[4]), 32'(mBit[i]));
         checkVal({NAME[i], ".ser_valid"},   32'(o[3]), 32'(mValid[i]));
         checkVal({NAME[i], ".frame_start"}, 32'(o[2]), 32'(mFs[i]));
         checkVal({NAME[i], ".busy"},        32'(o[1]), 32'(mValid[i]));
         checkVal({NAME[i], ".in_ready"},    32'(o[0]), 32'(!rst && pendCnt[i] == 0));
      end
   endtask

   // Drives the current inputs, clocks one edge, advances the model and compares.
   task automatic applyStimulus();
      bit acc [3];
      for (int i = 0; i < 3; i++) acc[i] = vValid[i] && !rst && (pendCnt[i] == 0);
      busA.in_valid = vValid[0];
      busA.in_data  = vData[0][7:0];
      busB.in_valid = vValid[1];
      busB.in_data  = vData[1][7:0];
      busC.in_valid = vValid[2];
      busC.in_data  = vData[2][2:0];
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (rst) modelReset(i);
         else     modelAdvance(i, acc[i]);
      end
      checkOutput();
   endtask

   task automatic sendWord(input int i, input logic [31:0] word, output logic [31:0] got,
                           output int nValid, output int nFs, output int fsFirst,
                           output logic lastReady);
      logic [4:0] o;
      got = '0; nValid = 0; nFs = 0; fsFirst = 0; lastReady = 1'b0;
      vValid[i] = 1'b1;
      vData[i]  = word;
      applyStimulus();
      vValid[i] = 1'b0;
      for (int k = 0; k < WID[i] + 3; k++) begin
         o = outs(i);
         if (o[3] === 1'b1) begin
            got = {got[30:0], o[4]};
            if (o[2] === 1'b1) begin
               nFs++;
               if (nValid == 0) fsFirst = 1;
            end
            nValid++;
            lastReady = o[0];
         end
         applyStimulus();
      end
   endtask

   initial begin
      logic [31:0] got;
      int          nV, nF, fsFirst;
      logic        lastRdy;
      logic [4:0]  o;
      logic [15:0] b2b;

      vecs[0] = '{0, 32'hA5, 8, 32'b10100101, 2};
      vecs[1] = '{0, 32'hF0, 8, 32'b11110000, 0};
      vecs[2] = '{1, 32'h01, 8, 32'b10000000, 0};
      vecs[3] = '{1, 32'h12, 8, 32'b01001000, 0};
      vecs[4] = '{1, 32'hA0, 8, 32'b00000101, 1};
      vecs[5] = '{2, 32'h2,  3, 32'b010,      0};
      vecs[6] = '{2, 32'h6,  3, 32'b110,      0};

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vValid[i] = 1'b0;
         vData[i]  = '0;
         modelReset(i);
      end
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      applyStimulus();

      for (int v = 0; v < 7; v++) begin
         sendWord(vecs[v].inst, vecs[v].word, got, nV, nF, fsFirst, lastRdy);
         checkVal($sformatf("vec%0d.bits", v),        got,               vecs[v].expSer);
         checkVal($sformatf("vec%0d.nbits", v),       nV,                vecs[v].nBits);
         checkVal($sformatf("vec%0d.frames", v),      nF,                1);
         checkVal($sformatf("vec%0d.fs_first", v),    fsFirst,           1);
         checkVal($sformatf("vec%0d.ready_last", v),  32'(lastRdy),      1);
         checkVal($sformatf("vec%0d.flag101", v),     count101(got, nV), vecs[v].exp101);
         o = outs(vecs[v].inst);
         checkVal($sformatf("vec%0d.idle_level", v),  32'(o[4]),         32'(IDL[vecs[v].inst]));
         checkVal($sformatf("vec%0d.idle_valid", v),  32'(o[3]),         0);
      end

      // Held in_valid with two words on A: 16 contiguous bits, ready only at T0 and T8.
      b2b = 16'hF00F;
      for (int k = 0; k < 16; k++) begin
         o = outs(0);
         checkVal($sformatf("b2b.ready_T%0d", k), 32'(o[0]), 32'(k == 0 || k == 8));
         vValid[0] = (k <= 8);
         vData[0]  = (k == 0) ? 32'hF0 : 32'h0F;
         applyStimulus();
         o = outs(0);
         checkVal($sformatf("b2b.bit_T%0d", k + 1),   32'(o[4]), 32'(b2b[15-k]));
         checkVal($sformatf("b2b.valid_T%0d", k + 1), 32'(o[3]), 1);
         checkVal($sformatf("b2b.fs_T%0d", k + 1),    32'(o[2]), 32'(k == 0 || k == 8));
      end
      vValid[0] = 1'b0;
      applyStimulus();
      o = outs(0);
      checkVal("b2b.tail_valid", 32'(o[3]), 0);

      // A pulse of in_valid in mid-word must not add bits.
      vValid[0] = 1'b1;
      vData[0]  = 32'hC3;
      applyStimulus();
      nV = 0; nF = 0;
      for (int k = 0; k < 12; k++) begin
         o = outs(0);
         if (o[3] === 1'b1) nV++;
         if (o[2] === 1'b1) nF++;
         vValid[0] = (k == 2);
         vData[0]  = 32'h3C;
         applyStimulus();
      end
      checkVal("busy_ignore.valid_bits", nV, 8);
      checkVal("busy_ignore.frames",     nF, 1);

      // Asynchronous reset at T4 of 8'hFF, then a clean restart.
      vValid[0] = 1'b1;
      vData[0]  = 32'hFF;
      applyStimulus();
      vValid[0] = 1'b0;
      repeat (3) applyStimulus();
      #2;
      rst = 1'b1;
      #1;
      o = outs(0);
      checkVal("rst_async.ser_data",  32'(o[4]), 0);
      checkVal("rst_async.ser_valid", 32'(o[3]), 0);
      checkVal("rst_async.in_ready",  32'(o[0]), 0);
      for (int i = 0; i < 3; i++) modelReset(i);
      checkOutput();
      applyStimulus();
      rst = 1'b0;
      applyStimulus();
      sendWord(0, 32'h81, got, nV, nF, fsFirst, lastRdy);
      checkVal("rst_restart.bits",   got, 32'h81);
      checkVal("rst_restart.nbits",  nV,  8);
      checkVal("rst_restart.frames", nF,  1);

      // Random traffic on all three instances, with one reset in the middle.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            vValid[i] = ($urandom_range(0, 3) != 0);
            vData[i]  = $urandom;
         end
         if (n == 200) rst = 1'b1;
         applyStimulus();
         rst = 1'b0;
      end
      for (int i = 0; i < 3; i++) vValid[i] = 1'b0;
      repeat (10) applyStimulus();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
